fp_add_stage: RTL and testbench
===============================

# fp_add_stage

Pipelined IEEE-754 single-precision adder stage that sits directly downstream of the multiplier output register in the filter datapath. It accepts one operand pair per cycle, qualified by a one-cycle `srdyi` pulse. It returns the rounded sum with a one-cycle `srdyo` pulse a fixed 4 cycles later. The registered sum is also exported as the running partial sum that the upstream stage feeds back as its `add_prev` operand.

## Interface

Parameters:
- `LATENCY`, default 4: pipeline depth from `srdyi` to `srdyo`. Fixed; any other value is unsupported.

Ports:
- `clk`, input, 1: rising-edge clock.
- `GlobalReset`, input, 1: one clock; reset is asynchronous and active-low.
- `srdyi`, input, 1: operand-valid pulse; operands are sampled on each edge where it is high.
- `add1_i`, input, 32: operand A (IEEE-754 single).
- `add2_i`, input, 32: operand B (IEEE-754 single).
- `sum_o`, output, 32: rounded sum; holds its value between results.
- `srdyo`, output, 1: result-valid pulse, high for exactly one cycle per accepted pair.
- `add_prev`, output, 32: copy of the last `sum_o`, for upstream feedback.
- `busy`, output, 1: OR of all in-flight valid bits.

## Operation

- No backpressure. Every `srdyi` edge is accepted, including back-to-back cycles.
- A valid bit travels with the data through stages S1–S4.
- S1, unpack/compare:
  - Split each operand into sign, exponent and mantissa; restore the hidden 1.
  - Flush denormal inputs (exp=0) to signed zero.
  - Swap so that operand A has the larger magnitude.
  - Classify specials.
- S2, align: right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits. A shift of 26 or more leaves only the sticky bit.
- S3, add: add when signs are equal, subtract when they differ. Use a 28-bit datapath (carry + 24 + G/R/S). The result sign is the sign of the larger operand.
- S4, normalize/round/pack:
  - On carry-out, right-shift by 1; otherwise left-shift by the leading-zero count.
  - Adjust the exponent to match.
  - Round to nearest, ties to even. If the mantissa overflows after rounding, renormalize.
- Output register: load `sum_o` and `add_prev` and pulse `srdyo` when the S4 valid bit is set.
- Special-case rules, in priority order:
  - Either input is NaN, or inf + (−inf): result `0x7FC00000`.
  - Either input is inf: that signed inf.
  - Exact cancellation (x + −x): `+0`, i.e. `0x00000000`.
  - Final exponent ≥ 255: signed inf (`0x7F800000` | sign).
  - Final exponent ≤ 0: flush to signed zero.
- Reset mid-operation clears every valid bit. In-flight pairs are discarded, and no `srdyo` is produced for them.

## Timing

- Reset values: `sum_o`=0, `add_prev`=0, `srdyo`=0, `busy`=0, and all pipeline valid bits 0. Reset acts immediately, without waiting for a clock edge.
- If `srdyi` is sampled high at edge N, `srdyo` is high in the cycle following edge N+4, and `sum_o` is valid in that same cycle.
- N results accepted on consecutive edges produce N consecutive `srdyo` pulses, in input order.
- `srdyo` is never asserted for two cycles by a single pair.
- `sum_o` and `add_prev` change only on `srdyo` cycles.
- `busy` is high in any cycle with an in-flight valid bit; it is 0 four cycles after the last `srdyi`.
- Deassertion of `GlobalReset` takes effect at the next edge. A `srdyi` on the first edge after release is accepted.

## Test plan

- **Basic add and latency:** 0x3F800000 + 0x40000000 (1.0 + 2.0) → `sum_o`=0x40400000, with `srdyo` exactly 4 edges after `srdyi` and `add_prev`=0x40400000.
- **Cancellation and subtraction:** 0x3F800000 + 0xBF800000 → 0x00000000. Then 0x40400000 + 0xBF800000 → 0x40000000.
- **Rounding:**
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000.
  - 0x3F800000 + 0x33C00000 (0.75 ulp) → 0x3F800001.
- **Specials and overflow:**
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - 0x00400000 (denormal) + 0x3F800000 → 0x3F800000.
- **Streaming:** send three pairs on consecutive edges (1+1, 2+2, 3+3) → three consecutive `srdyo` pulses with 0x40000000, 0x40800000, 0x40C00000.
- **Mid-flight reset:** pull `GlobalReset` low asynchronously 2 cycles after `srdyi` → outputs go to 0 immediately, no `srdyo` is ever produced for that pair, and a pair sent after release completes normally.

Source files
------------

// File: rtl/fp_add_stage.sv
// Four-stage IEEE-754 single-precision adder: unpack/compare, align, add, normalize/round.
// Denormals flush to zero and the result is rounded to nearest, ties to even.
module fp_add_stage #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        GlobalReset,
  input  logic        srdyi,
  input  logic [31:0] add1_i,
  input  logic [31:0] add2_i,
  output logic [31:0] sum_o,
  output logic        srdyo,
  output logic [31:0] add_prev,
  output logic        busy
);

  // Handshake: srdyi high at a rising edge means the operands are taken on that
  // edge (there is no stall). srdyo is a one-cycle pulse marking sum_o as new.
  // Results come out in input order.

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  logic [LATENCY-1:0] vld;

  // S1 unpack / compare
  logic        a_s, b_s, a_nan, b_nan, a_inf, b_inf, a_big;
  logic [23:0] a_m, b_m;
  logic        spec_n;
  logic [31:0] spec_val_n;

  always_comb begin
    a_s   = add1_i[31];
    b_s   = add2_i[31];
    a_m   = (add1_i[30:23] == 8'd0) ? 24'd0 : {1'b1, add1_i[22:0]};
    b_m   = (add2_i[30:23] == 8'd0) ? 24'd0 : {1'b1, add2_i[22:0]};
    a_nan = (add1_i[30:23] == 8'hFF) && (add1_i[22:0] != 23'd0);
    b_nan = (add2_i[30:23] == 8'hFF) && (add2_i[22:0] != 23'd0);
    a_inf = (add1_i[30:23] == 8'hFF) && (add1_i[22:0] == 23'd0);
    b_inf = (add2_i[30:23] == 8'hFF) && (add2_i[22:0] == 23'd0);
    a_big = {add1_i[30:23], a_m} >= {add2_i[30:23], b_m};
    spec_n     = 1'b0;
    spec_val_n = 32'd0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
      spec_n     = 1'b1;
      spec_val_n = 32'h7FC0_0000;
    end else if (a_inf) begin
      spec_n     = 1'b1;
      spec_val_n = {a_s, 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec_n     = 1'b1;
      spec_val_n = {b_s, 8'hFF, 23'd0};
    end
  end

  logic        s1_sign, s1_sub, s1_spec;
  logic [7:0]  s1_e, s1_diff;
  logic [23:0] s1_mb, s1_ms;
  logic [31:0] s1_spec_val;

  always_ff @(posedge clk) begin
    s1_sign     <= a_big ? a_s : b_s;
    s1_sub      <= a_s != b_s;
    s1_e        <= a_big ? add1_i[30:23] : add2_i[30:23];
    s1_diff     <= a_big ? (add1_i[30:23] - add2_i[30:23]) : (add2_i[30:23] - add1_i[30:23]);
    s1_mb       <= a_big ? a_m : b_m;
    s1_ms       <= a_big ? b_m : a_m;
    s1_spec     <= spec_n;
    s1_spec_val <= spec_val_n;
  end

  // S2 align: 24 mantissa bits + guard + round in a 26-bit window, the rest ORed into sticky
  logic [49:0] sh;
  logic [26:0] ms_al;

  always_comb begin
    sh = {s1_ms, 26'd0} >> s1_diff;
    if (s1_diff >= 8'd26) ms_al = {26'd0, |s1_ms};
    else                  ms_al = {sh[49:24], |sh[23:0]};
  end

  logic        s2_sign, s2_sub, s2_spec;
  logic [7:0]  s2_e;
  logic [26:0] s2_mb, s2_ms;
  logic [31:0] s2_spec_val;

  always_ff @(posedge clk) begin
    s2_sign     <= s1_sign;
    s2_sub      <= s1_sub;
    s2_e        <= s1_e;
    s2_mb       <= {s1_mb, 3'b000};
    s2_ms       <= ms_al;
    s2_spec     <= s1_spec;
    s2_spec_val <= s1_spec_val;
  end

  // S3 add; the larger magnitude is always on the left, so the difference never goes negative
  logic        s3_sign, s3_sub, s3_spec;
  logic [7:0]  s3_e;
  logic [27:0] s3_sum;
  logic [31:0] s3_spec_val;

  always_ff @(posedge clk) begin
    s3_sign     <= s2_sign;
    s3_sub      <= s2_sub;
    s3_e        <= s2_e;
    s3_sum      <= s2_sub ? ({1'b0, s2_mb} - {1'b0, s2_ms}) : ({1'b0, s2_mb} + {1'b0, s2_ms});
    s3_spec     <= s2_spec;
    s3_spec_val <= s2_spec_val;
  end

  // S4 normalize / round / pack
  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] exp_n, exp_r;
  logic              round_up;
  logic [24:0]       rnd;
  logic [22:0]       mant;
  logic [31:0]       res;

  always_comb begin
    lz    = lzc27(s3_sum[26:0]);
    norm  = s3_sum[26:0] << lz;
    exp_n = $signed({2'b00, s3_e}) - $signed({5'd0, lz});
    if (s3_sum[27]) begin
      norm  = {s3_sum[27:2], s3_sum[1] | s3_sum[0]};
      exp_n = $signed({2'b00, s3_e}) + 10'sd1;
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
    mant     = rnd[22:0];
    exp_r    = exp_n;
    if (rnd[24]) begin
      mant  = rnd[23:1];
      exp_r = exp_n + 10'sd1;
    end
    if (s3_spec)                res = s3_spec_val;
    else if (s3_sum == 28'd0)   res = {s3_sub ? 1'b0 : s3_sign, 31'd0};
    else if (exp_r >= 10'sd255) res = {s3_sign, 8'hFF, 23'd0};
    else if (exp_r <= 10'sd0)   res = {s3_sign, 31'd0};
    else                        res = {s3_sign, exp_r[7:0], mant};
  end

  logic [31:0] s4_res;

  always_ff @(posedge clk) begin
    s4_res <= res;
  end

  // Valid bits and the output register are the only state that sees reset
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      vld      <= '0;
      srdyo    <= 1'b0;
      sum_o    <= 32'd0;
      add_prev <= 32'd0;
    end else begin
      vld   <= {vld[LATENCY-2:0], srdyi};
      srdyo <= vld[LATENCY-1];
      if (vld[LATENCY-1]) begin
        sum_o    <= s4_res;
        add_prev <= s4_res;
      end
    end
  end

  assign busy = |vld;

endmodule

// File: tb/tb_fp_add_stage.sv
// Self-checking bench for fp_add_stage: directed cases plus randomized operands
// checked against an exact-integer floating-point reference model.
module tb_fp_add_stage;

  logic        clk = 1'b0;
  logic        GlobalReset = 1'b0;
  logic        srdyi = 1'b0;
  logic [31:0] add1_i = 32'd0;
  logic [31:0] add2_i = 32'd0;
  logic [31:0] sum_o, add_prev;
  logic        srdyo, busy;

  fp_add_stage #(.LATENCY(4)) dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .srdyi      (srdyi),
    .add1_i     (add1_i),
    .add2_i     (add2_i),
    .sum_o      (sum_o),
    .srdyo      (srdyo),
    .add_prev   (add_prev),
    .busy       (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int          due_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Exact reference: each operand becomes an integer scaled by 2^-150, the sum is
  // formed exactly and then rounded to 24 significant bits, ties to even.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic         sa, sb, s;
    logic [7:0]   ea, eb;
    logic [22:0]  fa, fb;
    logic [299:0] ia, ib, mag, rem, half;
    logic [24:0]  m;
    int           p, ex;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
        (ea == 8'hFF && eb == 8'hFF && sa != sb)) return 32'h7FC0_0000;
    if (ea == 8'hFF) return {sa, 8'hFF, 23'd0};
    if (eb == 8'hFF) return {sb, 8'hFF, 23'd0};
    ia = (ea == 0) ? 300'd0 : (300'({1'b1, fa}) << ea);
    ib = (eb == 0) ? 300'd0 : (300'({1'b1, fb}) << eb);
    if (ia >= ib) begin
      s = sa; mag = (sa == sb) ? ia + ib : ia - ib;
    end else begin
      s = sb; mag = (sa == sb) ? ia + ib : ib - ia;
    end
    if (mag == 0) return {(sa != sb) ? 1'b0 : sa, 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    ex = p - 23;
    if (ex <= 0) return {s, 31'd0};
    m    = 25'(mag >> (p - 23));
    rem  = mag & ((300'd1 << (p - 23)) - 300'd1);
    half = 300'd1 << (p - 24);
    if (rem > half || (rem == half && m[0])) m = m + 25'd1;
    if (m[24]) begin
      m  = m >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(ex), m[22:0]};
  endfunction

  // driver tasks
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
    @(negedge clk);
    srdyi  = 1'b1;
    add1_i = a;
    add2_i = b;
    exp_q.push_back(expv);
    due_q.push_back(edge_cnt + 5);
  endtask

  task automatic idle();
    @(negedge clk);
    srdyi = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    check32("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // monitor
  logic [31:0] mon_exp;
  int          mon_due;

  always @(negedge clk) begin
    if (GlobalReset && srdyo) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_srdyo: got srdyo=1 with sum_o %h, expected no result", sum_o);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_due = due_q.pop_front();
        check32("sum_o", sum_o, mon_exp);
        check32("add_prev", add_prev, mon_exp);
        check32("latency_edge", 32'(edge_cnt), 32'(mon_due));
      end
    end
  end

  function automatic logic [31:0] rnd_pair_b(input logic [31:0] a, input int mode);
    logic [31:0] b;
    int          e;
    b = $urandom;
    if (mode < 4) begin
      e = int'(a[30:23]) + int'($urandom_range(0, 6)) - 3;
      if (e < 0) e = 0;
      if (e > 254) e = 254;
      b[30:23] = 8'(e);
    end else if (mode == 4) begin
      b = {~a[31], a[30:0]} ^ 32'($urandom_range(0, 3));
    end
    return b;
  endfunction

  initial begin
    logic [31:0] a, b;
    int          mode;

    // reset state
    repeat (3) @(negedge clk);
    check32("reset_sum_o", sum_o, 32'd0);
    check32("reset_add_prev", add_prev, 32'd0);
    check32("reset_srdyo", {31'd0, srdyo}, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    GlobalReset = 1'b1;

    // basic add, latency and busy window
    send(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    idle();
    repeat (3) @(negedge clk);
    check32("busy_inflight", {31'd0, busy}, 32'd1);
    check32("srdyo_early", {31'd0, srdyo}, 32'd0);
    @(negedge clk);
    check32("busy_after4", {31'd0, busy}, 32'd0);
    drain();

    // cancellation, subtraction, rounding, specials, overflow, denormal
    send(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    send(32'h4040_0000, 32'hBF80_0000, 32'h4000_0000);
    send(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    send(32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001);
    send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    send(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    send(32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000);
    send(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
    drain();

    // streaming on consecutive edges
    send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    send(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    send(32'h4040_0000, 32'h4040_0000, 32'h40C0_0000);
    drain();

    // mid-flight reset: the killed pair has no queue entry, so any srdyo for it is flagged
    @(negedge clk);
    srdyi  = 1'b1;
    add1_i = 32'h4120_0000;
    add2_i = 32'h3F80_0000;
    @(negedge clk);
    srdyi = 1'b0;
    @(negedge clk);
    #2 GlobalReset = 1'b0;
    #1;
    check32("rst_sum_o", sum_o, 32'd0);
    check32("rst_add_prev", add_prev, 32'd0);
    check32("rst_srdyo", {31'd0, srdyo}, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    GlobalReset = 1'b1;
    srdyi  = 1'b1;
    add1_i = 32'h4000_0000;
    add2_i = 32'h3F80_0000;
    exp_q.push_back(32'h4040_0000);
    due_q.push_back(edge_cnt + 5);
    drain();

    // randomized operands with gaps
    for (int n = 0; n < 400; n++) begin
      a    = $urandom;
      mode = int'($urandom_range(0, 8));
      b    = rnd_pair_b(a, mode);
      if (mode == 5) begin
        a[30:23] = 8'($urandom_range(250, 254));
        b[30:23] = a[30:23];
        b[31]    = a[31];
      end else if (mode == 6) begin
        a[30:23] = 8'($urandom_range(0, 3));
        b[30:23] = 8'($urandom_range(0, 3));
      end else if (mode == 7) begin
        a[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) a[22:0] = 23'd0;
      end
      send(a, b, ref_add(a, b));
      if ($urandom_range(0, 2) == 0) idle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
